// File: rtl/spi_pkg.sv
// Shared SPI slave definitions used by the result transmitter and the matrix-load receiver.
// Latency: n/a (types and constants only). Backpressure: n/a.
package spi_pkg;
   typedef enum logic [2:0] {IDLE, CMD, FETCH, SHIFT, DONE, IGNORE} state_t;

   localparam logic [7:0] CMD_READ = 8'h30;
   localparam logic [7:0] CMD_LOAD = 8'h10;

   // Words cross the link low byte first; bits within a byte go MSB first.
   localparam bit BYTE_LSB_FIRST = 1'b1;
endpackage

// File: rtl/spi_pin_sync.sv
// Synchronises sclk/cs_n/mosi into clk and flags sclk and cs_n edges.
// Latency: SYNC_STAGES+1 clk from pin to edge pulse. Backpressure: none, free-running.
module spi_pin_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sclk,
   input  logic cs_n,
   input  logic mosi,
   output logic mosi_s,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic cs_rise,
   output logic cs_fall
);
   logic [SYNC_STAGES-1:0] sclk_sr;
   logic [SYNC_STAGES-1:0] cs_sr;
   logic [SYNC_STAGES-1:0] mosi_sr;
   logic                   sclk_d;
   logic                   cs_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sr <= '0;
         cs_sr   <= '1;
         mosi_sr <= '0;
         sclk_d  <= 1'b0;
         cs_d    <= 1'b1;
      end else begin
         sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], sclk};
         cs_sr   <= {cs_sr[SYNC_STAGES-2:0], cs_n};
         mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
         sclk_d  <= sclk_sr[SYNC_STAGES-1];
         cs_d    <= cs_sr[SYNC_STAGES-1];
      end
   end

   assign mosi_s    = mosi_sr[SYNC_STAGES-1];
   assign sclk_rise =  sclk_sr[SYNC_STAGES-1] & ~sclk_d;
   assign sclk_fall = ~sclk_sr[SYNC_STAGES-1] &  sclk_d;
   assign cs_rise   =  cs_sr[SYNC_STAGES-1] & ~cs_d;
   assign cs_fall   = ~cs_sr[SYNC_STAGES-1] &  cs_d;
endmodule

// File: rtl/spi_result_tx.sv
// SPI mode-0 slave streaming the result matrix on miso; SPI_TX_CHECKSUM_EN appends an XOR byte.
// Latency: one result-buffer fetch (2 clk) per word, hidden inside an sclk half-period. Backpressure: none, host paces via sclk.
module spi_result_tx #(
   parameter int          N_ELEM      = 16,
   parameter int          DATA_W      = 16,
   parameter logic [7:0]  CMD_READ    = spi_pkg::CMD_READ,
   parameter int          SYNC_STAGES = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      sclk,
   input  logic                      cs_n,
   input  logic                      mosi,
   output logic                      miso,
   output logic                      miso_oe,
   output logic                      res_rd_en,
   output logic [$clog2(N_ELEM)-1:0] res_addr,
   input  logic [DATA_W-1:0]         res_data,
   input  logic                      result_valid,
   output logic                      result_ack,
   output logic                      busy
);
   import spi_pkg::*;

   localparam int             AW   = $clog2(N_ELEM);
   localparam logic [AW-1:0]  LAST = AW'(N_ELEM - 1);

   state_t            state;
   logic [2:0]        bit_cnt;
   logic              byte_idx;
   logic [AW-1:0]     elem;
   logic [7:0]        cmd_sr;
   logic [7:0]        cmd_next;
   logic [DATA_W-1:0] word_q;
   logic [7:0]        cur_byte;
   logic              hi_sel;
   logic              mosi_s;
   logic              sclk_rise;
   logic              sclk_fall;
   logic              cs_rise;
   logic              cs_fall;
`ifdef SPI_TX_CHECKSUM_EN
   logic              ck_phase;
   logic [7:0]        csum;
`endif

   spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .rst_n     (rst_n),
      .sclk      (sclk),
      .cs_n      (cs_n),
      .mosi      (mosi),
      .mosi_s    (mosi_s),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall),
      .cs_rise   (cs_rise),
      .cs_fall   (cs_fall)
   );

   assign cmd_next = {cmd_sr[6:0], mosi_s};
   assign hi_sel   = BYTE_LSB_FIRST ? byte_idx : ~byte_idx;
   assign busy     = (state != IDLE);

   always_comb begin
      cur_byte = hi_sel ? word_q[15:8] : word_q[7:0];
`ifdef SPI_TX_CHECKSUM_EN
      if (ck_phase) cur_byte = csum;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         byte_idx   <= 1'b0;
         elem       <= '0;
         cmd_sr     <= '0;
         word_q     <= '0;
         miso       <= 1'b0;
         miso_oe    <= 1'b0;
         res_rd_en  <= 1'b0;
         res_addr   <= '0;
         result_ack <= 1'b0;
`ifdef SPI_TX_CHECKSUM_EN
         ck_phase   <= 1'b0;
         csum       <= '0;
`endif
      end else begin
         res_rd_en  <= 1'b0;
         result_ack <= 1'b0;
         // cs_n release wins over any sclk edge seen in the same cycle
         if (cs_rise) begin
            state   <= IDLE;
            miso    <= 1'b0;
            miso_oe <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (cs_fall) begin
                     state    <= CMD;
                     bit_cnt  <= '0;
                     byte_idx <= 1'b0;
                     elem     <= '0;
                     res_addr <= '0;
`ifdef SPI_TX_CHECKSUM_EN
                     ck_phase <= 1'b0;
                     csum     <= '0;
`endif
                  end
               end
               CMD: begin
                  if (sclk_rise) begin
                     cmd_sr  <= cmd_next;
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
                        if (cmd_next == CMD_READ && result_valid) begin
                           state     <= FETCH;
                           res_rd_en <= 1'b1;
                           res_addr  <= '0;
                        end else begin
                           state <= IGNORE;
                        end
                     end
                  end
               end
               FETCH: begin
                  // res_data is valid the cycle after the strobe drops
                  if (!res_rd_en) begin
                     word_q <= res_data;
                     state  <= SHIFT;
                  end
               end
               SHIFT: begin
                  miso_oe <= 1'b1;
                  if (sclk_fall) begin
                     miso <= cur_byte[3'd7 - bit_cnt];
                  end else if (sclk_rise) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'd7) begin
`ifdef SPI_TX_CHECKSUM_EN
                        csum <= csum ^ cur_byte;
                        if (ck_phase) begin
                           state      <= DONE;
                           result_ack <= 1'b1;
                        end else
`endif
                        if (!byte_idx) begin
                           byte_idx <= 1'b1;
                        end else begin
                           byte_idx <= 1'b0;
                           elem     <= elem + 1'b1;
                           if (elem == LAST) begin
`ifdef SPI_TX_CHECKSUM_EN
                              ck_phase <= 1'b1;
`else
                              state      <= DONE;
                              result_ack <= 1'b1;
`endif
                           end else begin
                              res_rd_en <= 1'b1;
                              res_addr  <= elem + 1'b1;
                              state     <= FETCH;
                           end
                        end
                     end
                  end
               end
               DONE: begin
                  miso <= 1'b0;
               end
               IGNORE: begin
                  miso    <= 1'b0;
                  miso_oe <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_spi_result_tx.sv
// Directed bench for spi_result_tx: expected miso bytes and buffer addresses are queued by the
// stimulus and consumed by independent monitors on sclk rise and on res_rd_en.
module tb_spi_result_tx;
   localparam int N_ELEM = 16;
   localparam int HALF   = 6;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sclk = 1'b0;
   logic        cs_n = 1'b1;
   logic        mosi = 1'b0;
   logic        miso;
   logic        miso_oe;
   logic        res_rd_en;
   logic [3:0]  res_addr;
   logic [15:0] res_data = '0;
   logic        result_valid = 1'b0;
   logic        result_ack;
   logic        busy;

   logic [15:0] mem [N_ELEM];
   logic [7:0]  exp_q [$];
   logic [3:0]  addr_q [$];
   logic        mon_en = 1'b0;
   int          ack_cnt = 0;
   int          checks = 0;
   int          errors = 0;

   spi_result_tx dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sclk         (sclk),
      .cs_n         (cs_n),
      .mosi         (mosi),
      .miso         (miso),
      .miso_oe      (miso_oe),
      .res_rd_en    (res_rd_en),
      .res_addr     (res_addr),
      .res_data     (res_data),
      .result_valid (result_valid),
      .result_ack   (result_ack),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   // result buffer: one-cycle read latency
   always @(posedge clk) if (res_rd_en) res_data <= mem[res_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic half();
      repeat (HALF) @(negedge clk);
   endtask

   task automatic xfer(input logic [7:0] tx);
      for (int i = 7; i >= 0; i--) begin
         mosi = tx[i];
         half();
         sclk = 1'b1;
         half();
         sclk = 1'b0;
      end
   endtask

   task automatic start(input logic [7:0] cmd);
      cs_n = 1'b0;
      half();
      xfer(cmd);
   endtask

   task automatic stop();
      half();
      cs_n = 1'b1;
      repeat (8) @(negedge clk);
   endtask

   task automatic read_bytes(input int n);
      mon_en = 1'b1;
      for (int i = 0; i < n; i++) xfer(8'h00);
      mon_en = 1'b0;
   endtask

   // queue a full readout of mem, plus the trailing XOR byte when that feature is built
   task automatic queue_readout();
      logic [7:0] ck;
      ck = 8'h00;
      for (int i = 0; i < N_ELEM; i++) begin
         addr_q.push_back(4'(i));
         exp_q.push_back(mem[i][7:0]);
         exp_q.push_back(mem[i][15:8]);
         ck = ck ^ mem[i][7:0] ^ mem[i][15:8];
      end
`ifdef SPI_TX_CHECKSUM_EN
      exp_q.push_back(ck);
`endif
   endtask

   localparam int READOUT_BYTES =
`ifdef SPI_TX_CHECKSUM_EN
      2 * N_ELEM + 1;
`else
      2 * N_ELEM;
`endif

   // miso monitor: host samples on sclk rise
   initial begin
      logic [7:0] sh;
      logic [7:0] e;
      int nb;
      nb = 0;
      sh = '0;
      forever begin
         @(posedge sclk);
         if (mon_en) begin
            sh = {sh[6:0], miso};
            nb++;
            if (nb == 8) begin
               nb = 0;
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL miso_byte unexpected byte %02h", sh);
               end else begin
                  e = exp_q.pop_front();
                  if (sh !== e) begin
                     errors++;
                     $display("FAIL miso_byte got %02h expected %02h", sh, e);
                  end
               end
            end
         end
      end
   end

   // buffer-read monitor
   initial begin
      logic [3:0] ea;
      forever begin
         @(negedge clk);
         if (res_rd_en) begin
            checks++;
            if (addr_q.size() == 0) begin
               errors++;
               $display("FAIL res_rd_en unexpected read addr %0d", res_addr);
            end else begin
               ea = addr_q.pop_front();
               if (res_addr !== ea) begin
                  errors++;
                  $display("FAIL res_addr got %0d expected %0d", res_addr, ea);
               end
            end
         end
      end
   end

   always @(negedge clk) if (result_ack) ack_cnt++;

   initial begin
      #2ms;
      $display("FAIL watchdog timeout");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int ack0;
      for (int i = 0; i < N_ELEM; i++) mem[i] = 16'h0100 + 16'(i);
      repeat (3) @(negedge clk);
      check("reset_miso", miso, 0);
      check("reset_oe", miso_oe, 0);
      check("reset_rd_en", res_rd_en, 0);
      check("reset_addr", res_addr, 0);
      check("reset_ack", result_ack, 0);
      check("reset_busy", busy, 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // cs_n low, no sclk, then a non-read command
      cs_n = 1'b0;
      repeat (HALF) @(negedge clk);
      check("cs_low_miso", miso, 0);
      check("cs_low_oe", miso_oe, 0);
      check("cs_low_busy", busy, 1);
      check("cs_low_ack", result_ack, 0);
      xfer(8'h10);
      xfer(8'h00);
      check("load_cmd_oe", miso_oe, 0);
      check("load_cmd_miso", miso, 0);
      stop();
      check("load_cmd_ack", ack_cnt, 0);
      check("load_cmd_busy", busy, 0);

      // read command while result not ready
      result_valid = 1'b0;
      start(8'h30);
      xfer(8'h00);
      check("not_valid_oe", miso_oe, 0);
      check("not_valid_busy", busy, 1);
      stop();
      check("not_valid_busy_after", busy, 0);
      check("not_valid_ack", ack_cnt, 0);
      result_valid = 1'b1;

      // full readout of 16'h0100+i
      queue_readout();
      start(8'h30);
      read_bytes(READOUT_BYTES);
      half();
      check("full_ack", ack_cnt, 1);
      check("full_bytes_left", exp_q.size(), 0);
      check("full_addr_left", addr_q.size(), 0);
      stop();
      check("full_busy_after", busy, 0);

      // abort after 5 bytes, then restart from elem 0
      ack0 = ack_cnt;
      for (int i = 0; i < 3; i++) addr_q.push_back(4'(i));
      exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h01);
      exp_q.push_back(8'h01); exp_q.push_back(8'h02);
      start(8'h30);
      read_bytes(5);
      stop();
      check("abort_ack", ack_cnt, ack0);
      check("abort_busy", busy, 0);
      addr_q.push_back(4'd0); addr_q.push_back(4'd1);
      exp_q.push_back(8'h00); exp_q.push_back(8'h01);
      start(8'h30);
      read_bytes(2);
      stop();
      check("restart_ack", ack_cnt, ack0);
      check("restart_bytes_left", exp_q.size(), 0);
      check("restart_addr_left", addr_q.size(), 0);

`ifdef SPI_TX_CHECKSUM_EN
      // all 16'h0001: sixteen 01 bytes cancel to 00
      for (int i = 0; i < N_ELEM; i++) mem[i] = 16'h0001;
      queue_readout();
      check("ck1_expected", exp_q[READOUT_BYTES-1], 8'h00);
      start(8'h30);
      read_bytes(READOUT_BYTES);
      half();
      check("ck1_ack", ack_cnt, ack0 + 1);
      stop();
      // single A5 byte: checksum equals it
      for (int i = 0; i < N_ELEM; i++) mem[i] = 16'h0000;
      mem[0] = 16'h00A5;
      queue_readout();
      check("ck2_expected", exp_q[READOUT_BYTES-1], 8'hA5);
      start(8'h30);
      read_bytes(READOUT_BYTES);
      half();
      check("ck2_ack", ack_cnt, ack0 + 2);
      stop();
      check("ck_bytes_left", exp_q.size(), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
